led_pwm_fader: RTL
==================

Name: led_pwm_fader

Overview:
- Downstream consumer of the run-LED pattern generator; takes its 10-bit `runled` pattern and drives the physical LED pins.
- Each LED channel has a brightness level. The level ramps toward full-on or full-off at a programmable rate.
- Brightness is rendered as PWM, so pattern steps appear as smooth fades instead of hard toggles.
- Level changes are applied only at PWM period boundaries, so pins never glitch mid-period.

Parameters:
- NUM_LEDS, 10, number of channels; must match the pattern generator width.
- PWM_BITS, 8, width of the level and PWM counter. PWM_MAX = 2^PWM_BITS-1 = 255.
- RAMP_DIV, 20'd1000, clk cycles per ramp tick; legal range 1..2^20-1.
- STEP, 8'd16, level change per ramp tick; legal range 1..PWM_MAX.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- runled_in  input  NUM_LEDS  target pattern from the LED generator; bit=1 means target PWM_MAX, bit=0 means target 0.
- enable  input  1  1 = fade/PWM running; 0 = pins dark, state frozen.
- led_out  output  NUM_LEDS  registered PWM drive to the pins.
- busy  output  1  high while any channel's shadow level differs from its current target.

Behaviour:
- Reset (reset=0, asynchronous):
  - pwm_cnt=0, ramp_cnt=0, all level_shadow=0, all level_active=0, led_out=0.
  - busy is combinational, so during and after reset busy = |runled_in.
- PWM counter:
  - pwm_cnt counts 0..PWM_MAX-1 (0..254), then wraps to 0. Period is 255 cycles.
  - Wrap event: pwm_cnt==PWM_MAX-1 while enable=1.
- Output stage:
  - led_out[i] <= enable & (level_active[i] > pwm_cnt). Latency is one cycle from the pwm_cnt value to the pin.
  - Level 0 gives a pin that is never high. Level 255 gives a pin that is always high.
- Ramp divider:
  - ramp_cnt counts 0..RAMP_DIV-1. tick=1 in the cycle where ramp_cnt==RAMP_DIV-1 and enable=1, then ramp_cnt wraps to 0.
  - RAMP_DIV=1 gives a tick every enabled cycle.
- Ramp step, on tick, per channel i, with target = runled_in[i] ? PWM_MAX : 0:
  - level_shadow < target: add STEP in PWM_BITS+1 bits, then saturate to PWM_MAX.
  - level_shadow > target: subtract STEP in PWM_BITS+1 bits, then clamp at 0.
  - Equal: hold.
  - runled_in is sampled only on tick. A pattern bit that toggles between ticks is not seen; there is no latching.
- Shadow-to-active transfer:
  - level_active[i] <= level_shadow[i] on the PWM wrap event only.
  - This holds duty cycle constant within a period.
  - If tick and wrap coincide, the transfer takes the pre-tick shadow value; the new value transfers on the next wrap.
- enable=0:
  - pwm_cnt and ramp_cnt are held at 0; no ticks and no transfers occur.
  - Levels hold their values.
  - led_out is 0 from the next edge.
- enable rising:
  - Counting restarts from 0.
  - The first tick comes RAMP_DIV cycles later.
  - The first wrap comes PWM_MAX cycles later.
- busy = OR over i of (level_shadow[i] != target[i]). It updates combinationally when runled_in changes.
- Reset mid-fade: all levels go to 0 immediately; there is no fade-out.

Decomposition:
- Package led_pkg:
  - NUM_LEDS and PWM_BITS defaults.
  - PWM_MAX constant.
  - A level_t typedef of PWM_BITS bits.
- Shared by the pattern generator and this block.
- Sub-module led_ramp_channel, instantiated NUM_LEDS times via generate:
  - Contains the saturating up/down step, the shadow and active registers, and the compare to pwm_cnt.
  - Inputs: clk, reset, tick, wrap, target bit, pwm_cnt.
  - Outputs: pwm bit, mismatch flag.
- The top level holds pwm_cnt, ramp_cnt, enable gating, and the busy OR-reduce.

Test Plan:
- Reset check: hold reset=0 with runled_in=10'h001 → led_out=0 and busy=1 throughout. Release with enable=0 → led_out stays 0 and no level changes.
- Fade-up (RAMP_DIV=4, STEP=64, runled_in=10'h001, enable=1):
  - Ticks at cycles 4, 8, 12, 16 → level_shadow[0] = 64, 128, 192, 255 (saturated, not 256).
  - busy falls after the 4th tick.
  - Once level_active[0]=255, led_out[0]=1 every cycle of a PWM period.
- Duty cycle: with level_active[0]=64 → led_out[0] high for exactly 64 of 255 cycles per period (pwm_cnt 0..63, seen one cycle later).
- Fade-down with clamp: STEP=100 from level 255, runled_in=0 → 155, 55, 0 (clamped). Channel 0 ends fully dark; busy=0.
- Glitch-free update: tick lands mid-period → led_out duty in the current period is unchanged; the new duty appears only after the next pwm_cnt wrap. Include the case where tick and wrap coincide.
- Enable and reset mid-operation:
  - Drop enable at level 128 → led_out=0 next edge, levels frozen. Re-raise → next tick exactly RAMP_DIV cycles later.
  - Assert reset mid-fade → all levels 0 immediately.

Source files
------------

// File: rtl/led_pkg.sv
// Shared LED-path definitions used by the run-LED pattern generator and the
// PWM fader.
package led_pkg;

  localparam int unsigned DEF_NUM_LEDS = 10;
  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned PWM_MAX      = (1 << DEF_PWM_BITS) - 1;

  typedef logic [DEF_PWM_BITS-1:0] level_t;

endpackage

// File: rtl/led_ramp_channel.sv
// One LED channel: saturating brightness ramp into a shadow level, transferred
// to the active level at PWM period boundaries, then compared against pwm_cnt.
module led_ramp_channel
  import led_pkg::*;
#(
  parameter int unsigned         PWM_BITS = DEF_PWM_BITS,
  parameter logic [PWM_BITS-1:0] STEP     = PWM_BITS'(16)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                wrap,
  input  logic                target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_bit,
  output logic                mismatch
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  logic [PWM_BITS-1:0] level_shadow;
  logic [PWM_BITS-1:0] level_active;
  logic [PWM_BITS-1:0] target_lvl;
  logic [PWM_BITS-1:0] next_lvl;
  logic [PWM_BITS:0]   sum;
  logic [PWM_BITS:0]   diff;

  assign target_lvl = target ? LVL_MAX : '0;

  // One extra bit catches overflow on the way up and borrow on the way down.
  always_comb begin
    sum      = {1'b0, level_shadow} + {1'b0, STEP};
    diff     = {1'b0, level_shadow} - {1'b0, STEP};
    next_lvl = level_shadow;
    if (level_shadow < target_lvl) begin
      next_lvl = sum[PWM_BITS] ? LVL_MAX : sum[PWM_BITS-1:0];
    end else if (level_shadow > target_lvl) begin
      next_lvl = diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0];
    end
  end

  // On a coincident tick and wrap, active takes the pre-tick shadow value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_shadow <= '0;
      level_active <= '0;
    end else begin
      if (tick) begin
        level_shadow <= next_lvl;
      end
      if (wrap) begin
        level_active <= level_shadow;
      end
    end
  end

  assign pwm_bit  = level_active > pwm_cnt;
  assign mismatch = level_shadow != target_lvl;

endmodule

// File: rtl/led_pwm_fader.sv
// Fades each run-LED pin toward on/off with a PWM brightness ramp; shared PWM
// and ramp counters, registered pin drive, combinational busy.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned         NUM_LEDS = DEF_NUM_LEDS,
  parameter int unsigned         PWM_BITS = DEF_PWM_BITS,
  parameter logic [19:0]         RAMP_DIV = 20'd1000,
  parameter logic [PWM_BITS-1:0] STEP     = PWM_BITS'(16)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] runled_in,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  // PWM period is PWM_MAX cycles, so the counter stops one short of all-ones.
  localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [19:0]         RAMP_LAST = RAMP_DIV - 20'd1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [19:0]         ramp_cnt;
  logic                tick;
  logic                wrap;
  logic [NUM_LEDS-1:0] pwm_bit;
  logic [NUM_LEDS-1:0] mismatch;

  assign wrap = enable && (pwm_cnt == CNT_LAST);
  assign tick = enable && (ramp_cnt == RAMP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
      led_out  <= '0;
    end else if (!enable) begin
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
      led_out  <= '0;
    end else begin
      pwm_cnt  <= wrap ? '0 : pwm_cnt + PWM_BITS'(1);
      ramp_cnt <= tick ? '0 : ramp_cnt + 20'd1;
      led_out  <= pwm_bit;
    end
  end

  assign busy = |mismatch;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_ramp_channel #(
      .PWM_BITS (PWM_BITS),
      .STEP     (STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .wrap     (wrap),
      .target   (runled_in[i]),
      .pwm_cnt  (pwm_cnt),
      .pwm_bit  (pwm_bit[i]),
      .mismatch (mismatch[i])
    );
  end

endmodule
